i2c_target_regs: RTL and testbench
==================================

// Module: i2c_target_regs
// PURPOSE
//  I2C target (responder) with an 8-bit register-pointer protocol: the far end of the bus driven by our
//  i2c master. Oversamples SCL/SDA on the 12 MHz system clock, decodes START/STOP, matches a 7-bit address,
//  ACKs, and reads/writes a small external register file.
//  Used as an on-board bus stub/loopback target for bring-up and for self-test of the master at 100k/400k.
// PARAMETERS
//  DEV_ADDR   7'h48  7-bit target address (same as the PCF8591 default)
//  REGS       4      number of registers; pointer wraps modulo REGS (power of two, 2..256)
//  AW         2      pointer width = log2(REGS)
// PORTS
//  clk        in   1   system clock (12 MHz, >= 20x SCL)
//  rst_n      in   1   asynchronous active-low reset
//  scl_in     in   1   SCL pad input (asynchronous)
//  sda_in     in   1   SDA pad input (asynchronous)
//  sda_oe     out  1   1 = pull SDA low (open drain), 0 = release
//  wr_valid   out  1   one-cycle strobe: wr_data is written to register wr_addr
//  wr_addr    out  AW  write register index
//  wr_data    out  8   write data
//  rd_addr    out  AW  register index being read (held stable; rd_data sampled 1 clk after change)
//  rd_data    in   8   register contents for rd_addr (combinational or 1-cycle registered source)
//  busy       out  1   1 from matched-address ACK until STOP or re-START
// BEHAVIOUR
//  - Reset: sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, pointer=0, state IDLE.
//  - Sync: 2-FF synchronizers on scl_in/sda_in, plus one history stage for edge detection.
//    scl_rise/scl_fall = synced SCL edges. START = SDA falls while SCL high; STOP = SDA rises while SCL high.
//  - Bits sampled on scl_rise, MSB first. sda_oe only changes on the clk after scl_fall (never while SCL high).
//  - States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK_CHK, IGNORE.
//    IDLE: wait START -> ADDR (bit count 0).
//    ADDR: shift 8 bits; on 8th scl_rise: addr[7:1]==DEV_ADDR -> ADDR_ACK, else -> IGNORE.
//    ADDR_ACK: sda_oe=1 from next scl_fall through 9th scl_fall; busy=1.
//      R/W=0 -> PTR. R/W=1 -> RDATA; rd_addr=pointer, first data bit driven at that 9th scl_fall.
//    PTR: 8 bits; pointer <= byte[AW-1:0] (upper bits ignored); ACK -> WDATA.
//    WDATA: 8 bits; at the ACK scl_fall: wr_valid pulses 1 clk, wr_addr=pointer, pointer<=pointer+1 mod REGS;
//      ACK always given -> WDATA.
//    RDATA: drive bits of the byte latched at load (sda_oe = ~bit); after 8th bit release SDA -> RACK_CHK.
//    RACK_CHK: on scl_rise, SDA=0 (ACK): pointer+1, rd_addr updated, next byte loaded at scl_fall -> RDATA;
//      SDA=1 (NACK) -> IGNORE.
//    IGNORE: sda_oe=0, wait STOP/START.
//  - STOP in any state -> IDLE, sda_oe=0, busy=0; pointer retained.
//  - START in any state (repeated START) -> ADDR; pointer retained (write-pointer-then-read works).
//  - START/STOP win over a same-cycle bit event. Byte aborted mid-way: no wr_valid, no pointer change.
//  - Reset mid-transfer: immediate return to reset values, SDA released; bus recovers at next START.
//  - Latency: wr_valid 1-2 clk after ACK-cycle scl_fall; sda_oe 1-2 clk after scl_fall.
// TESTING
//  1 Write 0x90,0x01,0xA5,0x3C,STOP @100k -> 3 ACKs; wr_valid (1,0xA5), (2,0x3C); busy low after STOP.
//  2 Write 0x90,0x03 / Sr 0x91, read 3 bytes, ACK,ACK,NACK, regs {11,22,33,44} -> 0x44,0x11,0x22 (wrap).
//  3 Address 0x92 + data -> SDA never driven, no wr_valid, busy stays 0.
//  4 STOP after 4 bits of data byte -> no wr_valid, pointer unchanged; next write lands at the old pointer.
//  5 Assert rst_n=0 while driving a read 0 bit -> sda_oe=0 within 1 clk; following full transaction OK.
//  6 Repeat test 1 @400k (N=30 divider) -> same results; assert sda_oe never toggles while SCL high.

Source files
------------

// File: rtl/i2c_target_regs.sv
// I2C target with an 8-bit register pointer, oversampled on the system clock.
// Decodes START/STOP, matches DEV_ADDR, ACKs, and reads/writes an external register file.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h48,
    parameter int         REGS     = 4,
    parameter int         AW       = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic          wr_valid,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WDATA_ACK, RDATA, RACK_CHK, IGNORE
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    scl_q, sda_q;
    logic          scl_s, sda_s;
    logic          scl_rise, scl_fall, start_ev, stop_ev;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    sh_q, sh_d, tx_q, tx_d, rx_byte;
    logic [AW-1:0] ptr_q, ptr_d, ptr_inc;
    logic          oe_q, oe_d, wv_q, wv_d, busy_q, busy_d;
    logic [AW-1:0] wa_q, wa_d, ra_q, ra_d;
    logic [7:0]    wd_q, wd_d;
    logic          addr_match, byte_done;

    // Two sync stages plus one history stage; idle bus reads high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_in};
            sda_q <= {sda_q[1:0], sda_in};
        end
    end

    assign scl_s      = scl_q[1];
    assign sda_s      = sda_q[1];
    assign scl_rise   = scl_s & ~scl_q[2];
    assign scl_fall   = ~scl_s & scl_q[2];
    assign start_ev   = scl_s & scl_q[2] & sda_q[2] & ~sda_s;
    assign stop_ev    = scl_s & scl_q[2] & ~sda_q[2] & sda_s;
    assign rx_byte    = {sh_q[6:0], sda_s};
    assign byte_done  = scl_rise && (cnt_q == 4'd7);
    assign addr_match = (sh_q[6:0] == DEV_ADDR);
    assign ptr_inc    = AW'((int'(ptr_q) + 1) % REGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            tx_q    <= '0;
            ptr_q   <= '0;
            oe_q    <= 1'b0;
            wv_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            ra_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            ptr_q   <= ptr_d;
            oe_q    <= oe_d;
            wv_q    <= wv_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            ra_q    <= ra_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop_ev) begin
            state_d = IDLE;
        end else if (start_ev) begin
            state_d = ADDR;
        end else begin
            unique case (state_q)
                ADDR:
                    if (byte_done) state_d = addr_match ? ADDR_ACK : IGNORE;
                ADDR_ACK:
                    if (scl_fall && cnt_q == 4'd1) state_d = sh_q[0] ? RDATA : PTR;
                PTR:
                    if (byte_done) state_d = PTR_ACK;
                PTR_ACK:
                    if (scl_fall && cnt_q == 4'd1) state_d = WDATA;
                WDATA:
                    if (byte_done) state_d = WDATA_ACK;
                WDATA_ACK:
                    if (scl_fall && cnt_q == 4'd1) state_d = WDATA;
                RDATA:
                    if (scl_fall && cnt_q == 4'd8) state_d = RACK_CHK;
                RACK_CHK:
                    if (scl_rise && sda_s) state_d = IGNORE;
                    else if (scl_fall && cnt_q == 4'd1) state_d = RDATA;
                default: state_d = state_q;
            endcase
        end
    end

    // In ACK states cnt_q marks whether the ACK bit is already being driven.
    always_comb begin
        cnt_d  = cnt_q;
        sh_d   = sh_q;
        tx_d   = tx_q;
        ptr_d  = ptr_q;
        oe_d   = oe_q;
        wv_d   = 1'b0;
        wa_d   = wa_q;
        wd_d   = wd_q;
        ra_d   = ra_q;
        busy_d = busy_q;
        if (stop_ev || start_ev) begin
            cnt_d  = '0;
            oe_d   = 1'b0;
            busy_d = 1'b0;
        end else begin
            unique case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        sh_d  = rx_byte;
                        cnt_d = byte_done ? 4'd0 : cnt_q + 4'd1;
                        if (byte_done && state_q == ADDR) ra_d = ptr_q;
                        if (byte_done && state_q == PTR) ptr_d = rx_byte[AW-1:0];
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall && cnt_q == 4'd0) begin
                        oe_d  = 1'b1;
                        cnt_d = 4'd1;
                        if (state_q == ADDR_ACK) busy_d = 1'b1;
                        if (state_q == WDATA_ACK) begin
                            wv_d  = 1'b1;
                            wa_d  = ptr_q;
                            wd_d  = sh_q;
                            ptr_d = ptr_inc;
                        end
                    end else if (scl_fall) begin
                        cnt_d = 4'd0;
                        oe_d  = 1'b0;
                        if (state_q == ADDR_ACK && sh_q[0]) begin
                            tx_d = rd_data;
                            oe_d = ~rd_data[7];
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d = 4'd0;
                        oe_d  = 1'b0;
                    end else if (scl_fall) begin
                        tx_d = {tx_q[6:0], 1'b0};
                        oe_d = ~tx_q[6];
                    end
                end
                RACK_CHK: begin
                    if (scl_rise && !sda_s) begin
                        ptr_d = ptr_inc;
                        ra_d  = ptr_inc;
                        cnt_d = 4'd1;
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        tx_d  = rd_data;
                        oe_d  = ~rd_data[7];
                        cnt_d = 4'd0;
                    end
                end
                default: oe_d = 1'b0;
            endcase
        end
    end

    assign sda_oe   = oe_q;
    assign wr_valid = wv_q;
    assign wr_addr  = wa_q;
    assign wr_data  = wd_q;
    assign rd_addr  = ra_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, register file model,
// write/read scoreboards and an SCL-high SDA-stability monitor.
`timescale 1ns/1ps
module tb_i2c_target_regs;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_drv = 1'b1;
    logic       sda_pull = 1'b0;
    logic       sda_line;
    logic       sda_oe, wr_valid, busy;
    logic [1:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;
    logic [7:0] regs [4];

    int checks = 0;
    int failures = 0;
    int hp = 60;
    int tog_hi = 0;
    int oe_cyc = 0;
    int busy_cyc = 0;
    logic scl_prev = 1'b1;
    logic oe_prev = 1'b0;

    typedef struct {
        logic [1:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        int         hp;
        logic [7:0] addr;
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ack;
        logic [1:0] ea0;
        logic [1:0] ea1;
    } vec_t;

    wr_t        exp_wr[$];
    wr_t        obs_wr[$];
    logic [7:0] exp_rd[$];
    vec_t       vecs[5];

    assign sda_line = ~(sda_pull | sda_oe);
    assign rd_data  = regs[rd_addr];

    always #5 clk = ~clk;

    i2c_target_regs #(
        .DEV_ADDR(7'h48),
        .REGS    (4),
        .AW      (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_in  (scl_drv),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .wr_valid(wr_valid),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    always @(posedge clk) begin
        if (wr_valid) regs[wr_addr] <= wr_data;
    end

    always @(negedge clk) begin
        if (wr_valid) obs_wr.push_back(wr_t'{wr_addr, wr_data});
        if (scl_prev && scl_drv && (sda_oe !== oe_prev)) tog_hi <= tog_hi + 1;
        if (sda_oe) oe_cyc <= oe_cyc + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
        scl_prev <= scl_drv;
        oe_prev  <= sda_oe;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic bit_out(input logic b);
        sda_pull = ~b;
        wait_clk(hp / 2);
        scl_drv = 1'b1;
        wait_clk(hp);
        scl_drv = 1'b0;
        wait_clk(hp / 2);
    endtask

    task automatic bit_in(output logic b);
        sda_pull = 1'b0;
        wait_clk(hp / 2);
        scl_drv = 1'b1;
        wait_clk(hp / 2);
        b = sda_line;
        wait_clk(hp - hp / 2);
        scl_drv = 1'b0;
        wait_clk(hp / 2);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack_line);
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(ack_line);
    endtask

    task automatic recv_byte(input string name, input logic nack);
        logic [7:0] d;
        logic       b;
        logic [7:0] e;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(nack);
        e = exp_rd.pop_front();
        chk(name, d, e);
    endtask

    task automatic i2c_start();
        wait_clk(hp / 2);
        sda_pull = 1'b1;
        wait_clk(hp / 2);
        scl_drv = 1'b0;
        wait_clk(hp / 2);
    endtask

    task automatic i2c_rstart();
        sda_pull = 1'b0;
        wait_clk(hp / 2);
        scl_drv = 1'b1;
        wait_clk(hp / 2);
        sda_pull = 1'b1;
        wait_clk(hp / 2);
        scl_drv = 1'b0;
        wait_clk(hp / 2);
    endtask

    task automatic i2c_stop();
        sda_pull = 1'b1;
        wait_clk(hp / 2);
        scl_drv = 1'b1;
        wait_clk(hp / 2);
        sda_pull = 1'b0;
        wait_clk(hp);
    endtask

    task automatic check_wr(input string name);
        wr_t e;
        wr_t o;
        wait_clk(4);
        chk({name, "_wr_count"}, obs_wr.size(), exp_wr.size());
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            chk({name, "_wr_addr"}, o.a, e.a);
            chk({name, "_wr_data"}, o.d, e.d);
        end
        exp_wr.delete();
        obs_wr.delete();
    endtask

    initial begin
        logic ack;
        int   oe0;
        int   busy0;

        vecs[0] = '{60, 8'h90, 8'h01, 8'hA5, 8'h3C, 1'b1, 2'd1, 2'd2};
        vecs[1] = '{15, 8'h90, 8'h01, 8'hA5, 8'h3C, 1'b1, 2'd1, 2'd2};
        vecs[2] = '{60, 8'h92, 8'h00, 8'h55, 8'hAA, 1'b0, 2'd0, 2'd0};
        vecs[3] = '{15, 8'h90, 8'hFF, 8'h77, 8'h88, 1'b1, 2'd3, 2'd0};
        vecs[4] = '{15, 8'h10, 8'h00, 8'h12, 8'h34, 1'b0, 2'd0, 2'd0};

        wait_clk(3);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        wait_clk(5);

        for (int v = 0; v < 5; v++) begin
            hp    = vecs[v].hp;
            oe0   = oe_cyc;
            busy0 = busy_cyc;
            i2c_start();
            send_byte(vecs[v].addr, ack);
            chk($sformatf("v%0d_addr_ack", v), ack, !vecs[v].ack);
            chk($sformatf("v%0d_busy_on", v), busy, vecs[v].ack);
            send_byte(vecs[v].ptr, ack);
            chk($sformatf("v%0d_ptr_ack", v), ack, !vecs[v].ack);
            if (vecs[v].ack) exp_wr.push_back(wr_t'{vecs[v].ea0, vecs[v].d0});
            send_byte(vecs[v].d0, ack);
            chk($sformatf("v%0d_d0_ack", v), ack, !vecs[v].ack);
            if (vecs[v].ack) exp_wr.push_back(wr_t'{vecs[v].ea1, vecs[v].d1});
            send_byte(vecs[v].d1, ack);
            chk($sformatf("v%0d_d1_ack", v), ack, !vecs[v].ack);
            i2c_stop();
            chk($sformatf("v%0d_busy_off", v), busy, 0);
            check_wr($sformatf("v%0d", v));
            if (!vecs[v].ack) begin
                chk($sformatf("v%0d_oe_quiet", v), oe_cyc - oe0, 0);
                chk($sformatf("v%0d_busy_quiet", v), busy_cyc - busy0, 0);
            end
        end

        // Load registers {11,22,33,44} via the bus.
        hp = 15;
        i2c_start();
        send_byte(8'h90, ack);
        send_byte(8'h00, ack);
        for (int i = 0; i < 4; i++) begin
            exp_wr.push_back(wr_t'{2'(i), 8'(8'h11 * (i + 1))});
            send_byte(8'(8'h11 * (i + 1)), ack);
        end
        i2c_stop();
        check_wr("init");

        // Pointer write, repeated START, read with wrap.
        i2c_start();
        send_byte(8'h90, ack);
        send_byte(8'h03, ack);
        chk("t2_ptr_ack", ack, 0);
        i2c_rstart();
        send_byte(8'h91, ack);
        chk("t2_rd_addr_ack", ack, 0);
        exp_rd.push_back(8'h44);
        exp_rd.push_back(8'h11);
        exp_rd.push_back(8'h22);
        recv_byte("t2_rd0", 1'b0);
        recv_byte("t2_rd1", 1'b0);
        recv_byte("t2_rd2", 1'b1);
        i2c_stop();
        check_wr("t2");

        // Abort a data byte after 4 bits; pointer must stay.
        i2c_start();
        send_byte(8'h90, ack);
        send_byte(8'h01, ack);
        exp_wr.push_back(wr_t'{2'd1, 8'hA5});
        send_byte(8'hA5, ack);
        for (int i = 0; i < 4; i++) bit_out(1'b1);
        i2c_stop();
        check_wr("t4");
        i2c_start();
        send_byte(8'h91, ack);
        chk("t4_rd_ack", ack, 0);
        exp_rd.push_back(8'h33);
        recv_byte("t4_rd_ptr_kept", 1'b1);
        i2c_stop();

        // Reset while the target drives a 0 data bit.
        hp = 60;
        i2c_start();
        send_byte(8'h91, ack);
        chk("t5_rd_ack", ack, 0);
        wait_clk(2);
        chk("t5_oe_before_rst", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_oe_in_rst", sda_oe, 0);
        chk("t5_busy_in_rst", busy, 0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        sda_pull = 1'b0;
        scl_drv = 1'b1;
        wait_clk(hp);
        i2c_start();
        send_byte(8'h90, ack);
        chk("t5_post_addr_ack", ack, 0);
        send_byte(8'h02, ack);
        exp_wr.push_back(wr_t'{2'd2, 8'h5A});
        send_byte(8'h5A, ack);
        chk("t5_post_data_ack", ack, 0);
        i2c_stop();
        check_wr("t5");
        i2c_start();
        send_byte(8'h90, ack);
        send_byte(8'h02, ack);
        i2c_rstart();
        send_byte(8'h91, ack);
        exp_rd.push_back(8'h5A);
        recv_byte("t5_readback", 1'b1);
        i2c_stop();

        chk("oe_toggle_scl_high", tog_hi, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
